// File: rtl/yt3817_video_pkg.sv
// Shared raster timing, pattern codes and bar geometry for the pixel-stream source.
// Timing values here are the defaults; the top exposes them as overridable parameters.
package yt3817_video_pkg;

    localparam int CNT_W = 12;

    localparam int VID_H_ACTIVE     = 800;
    localparam int VID_H_FP         = 40;
    localparam int VID_H_SYNC       = 128;
    localparam int VID_H_BP         = 88;
    localparam int VID_H_TOTAL      = VID_H_ACTIVE + VID_H_FP + VID_H_SYNC + VID_H_BP;
    localparam int VID_H_SYNC_START = VID_H_ACTIVE + VID_H_FP;
    localparam int VID_H_SYNC_END   = VID_H_SYNC_START + VID_H_SYNC;

    localparam int VID_V_ACTIVE     = 480;
    localparam int VID_V_FP         = 13;
    localparam int VID_V_SYNC       = 3;
    localparam int VID_V_BP         = 32;
    localparam int VID_V_TOTAL      = VID_V_ACTIVE + VID_V_FP + VID_V_SYNC + VID_V_BP;
    localparam int VID_V_SYNC_START = VID_V_ACTIVE + VID_V_FP;
    localparam int VID_V_SYNC_END   = VID_V_SYNC_START + VID_V_SYNC;

    localparam bit VID_SYNC_POL = 1'b0;

    typedef enum logic [1:0] {
        PAT_GREY = 2'd0,
        PAT_BAR  = 2'd1,
        PAT_ZERO = 2'd2,
        PAT_ONE  = 2'd3
    } pattern_e;

    // Bar rectangle forming the digit "1"; upper bounds are exclusive.
    localparam int BAR_H_START = 390;
    localparam int BAR_H_END   = 410;
    localparam int BAR_V_START = 114;
    localparam int BAR_V_END   = 366;

    function automatic logic in_window(input logic [CNT_W-1:0] pos,
                                       input logic [CNT_W-1:0] lo,
                                       input logic [CNT_W-1:0] hi);
        return (pos >= lo) && (pos < hi);
    endfunction

endpackage

// File: rtl/yt3817_raster_cnt.sv
// Horizontal/vertical raster counters; cleared while en is low, wrap at the totals.
module yt3817_raster_cnt
    import yt3817_video_pkg::*;
#(
    parameter int H_TOTAL = VID_H_TOTAL,
    parameter int V_TOTAL = VID_V_TOTAL
) (
    input  logic             clk,
    input  logic             arstn,
    input  logic             en,
    output logic [CNT_W-1:0] h_cnt,
    output logic [CNT_W-1:0] v_cnt
);

    localparam logic [CNT_W-1:0] H_LAST = CNT_W'(H_TOTAL - 1);
    localparam logic [CNT_W-1:0] V_LAST = CNT_W'(V_TOTAL - 1);

    logic [CNT_W-1:0] h_cnt_reg, h_cnt_next;
    logic [CNT_W-1:0] v_cnt_reg, v_cnt_next;

    always_comb begin
        h_cnt_next = h_cnt_reg;
        v_cnt_next = v_cnt_reg;
        if (!en) begin
            h_cnt_next = '0;
            v_cnt_next = '0;
        end else if (h_cnt_reg == H_LAST) begin
            h_cnt_next = '0;
            v_cnt_next = (v_cnt_reg == V_LAST) ? '0 : v_cnt_reg + 1'b1;
        end else begin
            h_cnt_next = h_cnt_reg + 1'b1;
        end
    end

    always_ff @(posedge clk or negedge arstn) begin
        if (!arstn) begin
            h_cnt_reg <= '0;
            v_cnt_reg <= '0;
        end else begin
            h_cnt_reg <= h_cnt_next;
            v_cnt_reg <= v_cnt_next;
        end
    end

    assign h_cnt = h_cnt_reg;
    assign v_cnt = v_cnt_reg;

endmodule

// File: rtl/yt3817_pixel_stream_src.sv
// Raster scan source: counters -> frame-buffer read -> binarize, with syncs and de,
// all outputs registered two clocks after the read address.
module yt3817_pixel_stream_src
    import yt3817_video_pkg::*;
#(
    parameter int H_ACTIVE = VID_H_ACTIVE,
    parameter int H_FP     = VID_H_FP,
    parameter int H_SYNC   = VID_H_SYNC,
    parameter int H_BP     = VID_H_BP,
    parameter int V_ACTIVE = VID_V_ACTIVE,
    parameter int V_FP     = VID_V_FP,
    parameter int V_SYNC   = VID_V_SYNC,
    parameter int V_BP     = VID_V_BP,
    parameter bit SYNC_POL = VID_SYNC_POL,
    parameter int BAR_H_LO = BAR_H_START,
    parameter int BAR_H_HI = BAR_H_END,
    parameter int BAR_V_LO = BAR_V_START,
    parameter int BAR_V_HI = BAR_V_END
) (
    input  logic             clk,
    input  logic             arstn,
    input  logic             en,
    input  logic [1:0]       pattern_sel,
    input  logic [7:0]       threshold,
    output logic [CNT_W-1:0] rd_h,
    output logic [CNT_W-1:0] rd_v,
    input  logic [7:0]       grey_in,
    output logic [CNT_W-1:0] H_Addr,
    output logic [CNT_W-1:0] V_Addr,
    output logic             bin_data,
    output logic             de,
    output logic             hsync,
    output logic             vsync,
    output logic             frame_start
);

    localparam int H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
    localparam int V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;

    localparam logic [CNT_W-1:0] H_ACT_C = CNT_W'(H_ACTIVE);
    localparam logic [CNT_W-1:0] V_ACT_C = CNT_W'(V_ACTIVE);
    localparam logic [CNT_W-1:0] SYNC_LO [2] = '{CNT_W'(H_ACTIVE + H_FP),
                                                 CNT_W'(V_ACTIVE + V_FP)};
    localparam logic [CNT_W-1:0] SYNC_HI [2] = '{CNT_W'(H_ACTIVE + H_FP + H_SYNC),
                                                 CNT_W'(V_ACTIVE + V_FP + V_SYNC)};
    localparam logic [CNT_W-1:0] BAR_LO  [2] = '{CNT_W'(BAR_H_LO), CNT_W'(BAR_V_LO)};
    localparam logic [CNT_W-1:0] BAR_HI  [2] = '{CNT_W'(BAR_H_HI), CNT_W'(BAR_V_HI)};

    // Stage 0: raster counters drive the frame-buffer address directly.
    logic [CNT_W-1:0] h0, v0;

    yt3817_raster_cnt #(
        .H_TOTAL(H_TOTAL),
        .V_TOTAL(V_TOTAL)
    ) u_raster_cnt (
        .clk  (clk),
        .arstn(arstn),
        .en   (en),
        .h_cnt(h0),
        .v_cnt(v0)
    );

    assign rd_h = h0;
    assign rd_v = v0;

    // Stage 1: coordinates delayed to line up with grey_in from the frame buffer.
    logic             valid1_reg;
    logic [CNT_W-1:0] h1_reg, v1_reg;

    always_ff @(posedge clk or negedge arstn) begin
        if (!arstn) begin
            valid1_reg <= 1'b0;
            h1_reg     <= '0;
            v1_reg     <= '0;
        end else begin
            valid1_reg <= en;
            h1_reg     <= en ? h0 : '0;
            v1_reg     <= en ? v0 : '0;
        end
    end

    // Mode and threshold only change on the frame boundary so a frame is never mixed.
    pattern_e   mode_reg;
    logic [7:0] thr_reg;

    always_ff @(posedge clk or negedge arstn) begin
        if (!arstn) begin
            mode_reg <= PAT_ZERO;
            thr_reg  <= '0;
        end else if (en && (h0 == '0) && (v0 == '0)) begin
            mode_reg <= pattern_e'(pattern_sel);
            thr_reg  <= threshold;
        end
    end

    // Per-axis decode: index 0 is horizontal, index 1 is vertical.
    logic [CNT_W-1:0] pos1 [2];
    logic [1:0]       sync_win;
    logic [1:0]       bar_win;
    logic [1:0]       sync_next;

    assign pos1[0] = h1_reg;
    assign pos1[1] = v1_reg;

    for (genvar gi = 0; gi < 2; gi++) begin : g_axis
        assign sync_win[gi]  = in_window(pos1[gi], SYNC_LO[gi], SYNC_HI[gi]);
        assign bar_win[gi]   = in_window(pos1[gi], BAR_LO[gi], BAR_HI[gi]);
        assign sync_next[gi] = (valid1_reg && sync_win[gi]) ? SYNC_POL : ~SYNC_POL;
    end

    logic de_next, bin_next, fs_next, pix_next;

    always_comb begin
        de_next  = valid1_reg && (h1_reg < H_ACT_C) && (v1_reg < V_ACT_C);
        fs_next  = valid1_reg && (h1_reg == '0) && (v1_reg == '0);
        pix_next = 1'b0;
        case (mode_reg)
            PAT_GREY: pix_next = (grey_in >= thr_reg);
            PAT_BAR:  pix_next = &bar_win;
            PAT_ZERO: pix_next = 1'b0;
            PAT_ONE:  pix_next = 1'b1;
            default:  pix_next = 1'b0;
        endcase
        bin_next = de_next && pix_next;
    end

    // Stage 2: every output registered on the same edge.
    logic [CNT_W-1:0] h_addr_reg, v_addr_reg;
    logic             de_reg, bin_reg, fs_reg, hsync_reg, vsync_reg;

    always_ff @(posedge clk or negedge arstn) begin
        if (!arstn) begin
            h_addr_reg <= '0;
            v_addr_reg <= '0;
            de_reg     <= 1'b0;
            bin_reg    <= 1'b0;
            fs_reg     <= 1'b0;
            hsync_reg  <= ~SYNC_POL;
            vsync_reg  <= ~SYNC_POL;
        end else begin
            h_addr_reg <= h1_reg;
            v_addr_reg <= v1_reg;
            de_reg     <= de_next;
            bin_reg    <= bin_next;
            fs_reg     <= fs_next;
            hsync_reg  <= sync_next[0];
            vsync_reg  <= sync_next[1];
        end
    end

    assign H_Addr      = h_addr_reg;
    assign V_Addr      = v_addr_reg;
    assign de          = de_reg;
    assign bin_data    = bin_reg;
    assign frame_start = fs_reg;
    assign hsync       = hsync_reg;
    assign vsync       = vsync_reg;

endmodule

// File: tb/tb_yt3817_pixel_stream_src.sv
// Bench for the pixel-stream source on a scaled-down raster so several frames fit in the run.
// A cycle model queues the expected stage-2 outputs; feature tasks check frame-level properties.
module tb_yt3817_pixel_stream_src;

    localparam int HA = 160, HFP = 8, HSW = 16, HBP = 8;
    localparam int HT = HA + HFP + HSW + HBP;
    localparam int VA = 24, VFP = 2, VSW = 3, VBP = 3;
    localparam int VT = VA + VFP + VSW + VBP;
    localparam int FRAME = HT * VT;
    localparam int BH0 = 60, BH1 = 80, BV0 = 6, BV1 = 18;

    logic        clk = 1'b0;
    logic        arstn = 1'b0;
    logic        en = 1'b0;
    logic [1:0]  pattern_sel = 2'd2;
    logic [7:0]  threshold = 8'd0;
    logic [7:0]  grey_in = 8'd0;
    logic [11:0] rd_h, rd_v, H_Addr, V_Addr;
    logic        bin_data, de, hsync, vsync, frame_start;

    int checks = 0;
    int failures = 0;

    typedef struct packed {
        logic [11:0] h;
        logic [11:0] v;
        logic        de;
        logic        bin;
        logic        hs;
        logic        vs;
        logic        fs;
    } exp_t;

    exp_t sb[$];

    yt3817_pixel_stream_src #(
        .H_ACTIVE(HA), .H_FP(HFP), .H_SYNC(HSW), .H_BP(HBP),
        .V_ACTIVE(VA), .V_FP(VFP), .V_SYNC(VSW), .V_BP(VBP),
        .SYNC_POL(1'b0),
        .BAR_H_LO(BH0), .BAR_H_HI(BH1), .BAR_V_LO(BV0), .BAR_V_HI(BV1)
    ) dut (
        .clk        (clk),
        .arstn      (arstn),
        .en         (en),
        .pattern_sel(pattern_sel),
        .threshold  (threshold),
        .rd_h       (rd_h),
        .rd_v       (rd_v),
        .grey_in    (grey_in),
        .H_Addr     (H_Addr),
        .V_Addr     (V_Addr),
        .bin_data   (bin_data),
        .de         (de),
        .hsync      (hsync),
        .vsync      (vsync),
        .frame_start(frame_start)
    );

    always #5 clk = ~clk;

    // Frame buffer with a registered read: each pixel's grey value is its column mod 256.
    always @(posedge clk) grey_in <= rd_h[7:0];

    // Reference raster: at each edge, queue what the pixel now at stage 0 must look like at stage 2.
    int         m_h = 0, m_v = 0;
    logic [1:0] m_mode = 2'd2;
    logic [7:0] m_thr = 8'd0;

    initial begin
        exp_t e;
        logic pix;
        forever begin
            @(posedge clk);
            if (!arstn) begin
                m_h = 0; m_v = 0; m_mode = 2'd2; m_thr = 8'd0;
                sb.delete();
            end else begin
                if (en && m_h == 0 && m_v == 0) begin
                    m_mode = pattern_sel;
                    m_thr  = threshold;
                end
                e.h  = en ? 12'(m_h) : 12'd0;
                e.v  = en ? 12'(m_v) : 12'd0;
                e.de = en && (m_h < HA) && (m_v < VA);
                case (m_mode)
                    2'd0:    pix = (8'(m_h) >= m_thr);
                    2'd1:    pix = (m_h >= BH0) && (m_h < BH1) && (m_v >= BV0) && (m_v < BV1);
                    2'd2:    pix = 1'b0;
                    default: pix = 1'b1;
                endcase
                e.bin = e.de && pix;
                e.hs  = !(en && (m_h >= HA + HFP) && (m_h < HA + HFP + HSW));
                e.vs  = !(en && (m_v >= VA + VFP) && (m_v < VA + VFP + VSW));
                e.fs  = en && (m_h == 0) && (m_v == 0);
                sb.push_back(e);
                if (!en) begin
                    m_h = 0; m_v = 0;
                end else if (m_h == HT - 1) begin
                    m_h = 0;
                    m_v = (m_v == VT - 1) ? 0 : m_v + 1;
                end else begin
                    m_h = m_h + 1;
                end
            end
        end
    end

    // Scoreboard: an entry queued at edge k is due after edge k+1.
    initial begin
        exp_t e, g;
        forever begin
            @(negedge clk);
            if (!arstn) begin
                sb.delete();
            end else if (sb.size() >= 2) begin
                e = sb.pop_front();
                g.h = H_Addr; g.v = V_Addr; g.de = de; g.bin = bin_data;
                g.hs = hsync; g.vs = vsync; g.fs = frame_start;
                checks++;
                if (g !== e) begin
                    failures++;
                    $display("FAIL scoreboard t=%0t got h=%0d v=%0d de=%b bin=%b hs=%b vs=%b fs=%b expected h=%0d v=%0d de=%b bin=%b hs=%b vs=%b fs=%b",
                             $time, g.h, g.v, g.de, g.bin, g.hs, g.vs, g.fs,
                             e.h, e.v, e.de, e.bin, e.hs, e.vs, e.fs);
                end
            end
        end
    end

    initial begin
        #800000;
        $display("FAIL watchdog run exceeded time limit");
        $fatal(1, "watchdog");
    end

    task automatic wait_fs(input int limit, output bit ok);
        ok = 1'b0;
        for (int i = 0; i < limit; i++) begin
            @(negedge clk);
            if (frame_start === 1'b1) begin
                ok = 1'b1;
                break;
            end
        end
    endtask

    task automatic test_reset();
        logic [52:0] got;
        for (int i = 0; i < 200; i++) begin
            @(negedge clk);
            if (i == 100) #1 arstn = 1'b1;
            else begin
                got = {rd_h, rd_v, H_Addr, V_Addr, de, bin_data, frame_start, hsync, vsync};
                checks++;
                if (got !== {48'd0, 5'b00011}) begin
                    failures++;
                    $display("FAIL reset_idle cycle=%0d got=%h expected=%h", i, got, {48'd0, 5'b00011});
                end
                $display("reset/idle cycle %0d arstn=%b en=%b de=%b hs=%b vs=%b", i, arstn, en, de, hsync, vsync);
            end
        end
    endtask

    task automatic test_mode2_timing();
        int hs_low = 0, vs_low = 0, de_cnt = 0, ones = 0;
        en = 1'b1;
        @(negedge clk);
        checks++;
        if (frame_start !== 1'b0) begin
            failures++; $display("FAIL start_early got fs=%b expected 0", frame_start);
        end
        @(negedge clk);
        checks++;
        if ({frame_start, H_Addr, V_Addr} !== {1'b1, 24'd0}) begin
            failures++;
            $display("FAIL start_latency got fs=%b h=%0d v=%0d expected fs=1 h=0 v=0", frame_start, H_Addr, V_Addr);
        end
        for (int i = 0; i < FRAME; i++) begin
            hs_low += (hsync == 1'b0);
            vs_low += (vsync == 1'b0);
            de_cnt += de;
            ones   += bin_data;
            @(negedge clk);
        end
        checks++;
        if (frame_start !== 1'b1) begin
            failures++; $display("FAIL frame_period got fs=%b after %0d clk expected 1", frame_start, FRAME);
        end
        checks++;
        if (hs_low != HSW * VT) begin
            failures++; $display("FAIL hsync_width got %0d expected %0d", hs_low, HSW * VT);
        end
        checks++;
        if (vs_low != VSW * HT) begin
            failures++; $display("FAIL vsync_width got %0d expected %0d", vs_low, VSW * HT);
        end
        checks++;
        if (de_cnt != HA * VA || ones != 0) begin
            failures++; $display("FAIL mode2_frame got de=%0d ones=%0d expected de=%0d ones=0", de_cnt, ones, HA * VA);
        end
        $display("mode2 frame: hs_low=%0d vs_low=%0d de=%0d ones=%0d", hs_low, vs_low, de_cnt, ones);
    endtask

    task automatic test_bar();
        bit ok;
        int ones = 0, fh = -1, fv = -1;
        pattern_sel = 2'd1;
        wait_fs(FRAME + 10, ok);
        checks++;
        if (!ok) begin
            failures++; $display("FAIL bar_wait_fs got timeout expected frame_start");
        end
        for (int i = 0; i < FRAME; i++) begin
            if (bin_data === 1'b1) begin
                if (ones == 0) begin fh = H_Addr; fv = V_Addr; end
                ones++;
            end
            if (i == BV0 * HT + BH0 - 1 || i == 10 * HT + BH1 || i == BV1 * HT + 70) begin
                checks++;
                if (bin_data !== 1'b0) begin
                    failures++; $display("FAIL bar_edge_out i=%0d got %b expected 0", i, bin_data);
                end
            end
            if (i == 10 * HT + BH1 - 1 || i == (BV1 - 1) * HT + 70) begin
                checks++;
                if (bin_data !== 1'b1) begin
                    failures++; $display("FAIL bar_edge_in i=%0d got %b expected 1", i, bin_data);
                end
            end
            @(negedge clk);
        end
        checks++;
        if (ones != (BH1 - BH0) * (BV1 - BV0) || fh != BH0 || fv != BV0) begin
            failures++;
            $display("FAIL bar_frame got ones=%0d first=(%0d,%0d) expected ones=%0d first=(%0d,%0d)",
                     ones, fh, fv, (BH1 - BH0) * (BV1 - BV0), BH0, BV0);
        end
        $display("bar frame: ones=%0d first=(%0d,%0d)", ones, fh, fv);
    endtask

    task automatic test_grey();
        bit ok;
        int ones = 0;
        pattern_sel = 2'd0;
        threshold   = 8'h80;
        wait_fs(FRAME + 10, ok);
        checks++;
        if (!ok) begin
            failures++; $display("FAIL grey_wait_fs got timeout expected frame_start");
        end
        for (int i = 0; i < HA; i++) begin
            ones += bin_data;
            if (i == 127 || i == 128) begin
                checks++;
                if (bin_data !== (i == 128)) begin
                    failures++; $display("FAIL grey_threshold H=%0d got %b expected %b", i, bin_data, i == 128);
                end
            end
            @(negedge clk);
        end
        checks++;
        if (ones != HA - 128) begin
            failures++; $display("FAIL grey_line got ones=%0d expected %0d", ones, HA - 128);
        end
        $display("grey thr=0x80 line0 ones=%0d", ones);
        threshold = 8'h00;
        ones = 0;
        wait_fs(FRAME + 10, ok);
        for (int i = 0; i < HA; i++) begin
            ones += bin_data;
            @(negedge clk);
        end
        checks++;
        if (!ok || ones != HA) begin
            failures++; $display("FAIL grey_thr0 got ok=%b ones=%0d expected ok=1 ones=%0d", ok, ones, HA);
        end
        $display("grey thr=0 line0 ones=%0d", ones);
    endtask

    task automatic test_switch();
        bit ok;
        int ones = 0, de_cnt = 0;
        pattern_sel = 2'd2;
        wait_fs(FRAME + 10, ok);
        for (int i = 0; i < FRAME; i++) begin
            ones += bin_data;
            if (i == 10 * HT) pattern_sel = 2'd3;
            @(negedge clk);
        end
        checks++;
        if (!ok || ones != 0 || frame_start !== 1'b1) begin
            failures++;
            $display("FAIL switch_same_frame got ok=%b ones=%0d fs=%b expected ok=1 ones=0 fs=1", ok, ones, frame_start);
        end
        ones = 0;
        for (int i = 0; i < FRAME; i++) begin
            ones   += bin_data;
            de_cnt += de;
            @(negedge clk);
        end
        checks++;
        if (ones != HA * VA || de_cnt != HA * VA) begin
            failures++; $display("FAIL switch_next_frame got ones=%0d de=%0d expected %0d", ones, de_cnt, HA * VA);
        end
        $display("switch 2->3: next frame ones=%0d de=%0d", ones, de_cnt);
    endtask

    task automatic test_en_drop();
        repeat (5 * HT + 100) @(negedge clk);
        checks++;
        if ({H_Addr, V_Addr, de, bin_data} !== {12'd100, 12'd5, 2'b11}) begin
            failures++; $display("FAIL en_drop_pre got h=%0d v=%0d de=%b bin=%b expected h=100 v=5 de=1 bin=1",
                                 H_Addr, V_Addr, de, bin_data);
        end
        en = 1'b0;
        @(negedge clk);
        @(negedge clk);
        checks++;
        if ({de, bin_data, frame_start, hsync, vsync} !== 5'b00011) begin
            failures++; $display("FAIL en_drop_drain got de=%b bin=%b fs=%b hs=%b vs=%b expected 0 0 0 1 1",
                                 de, bin_data, frame_start, hsync, vsync);
        end
        repeat (10) @(negedge clk);
        checks++;
        if ({rd_h, rd_v, H_Addr, V_Addr} !== 48'd0) begin
            failures++; $display("FAIL en_low_hold got rd=(%0d,%0d) addr=(%0d,%0d) expected zeros", rd_h, rd_v, H_Addr, V_Addr);
        end
        en = 1'b1;
        @(negedge clk);
        checks++;
        if (frame_start !== 1'b0) begin
            failures++; $display("FAIL en_raise_early got fs=%b expected 0", frame_start);
        end
        @(negedge clk);
        checks++;
        if (frame_start !== 1'b1) begin
            failures++; $display("FAIL en_raise_start got fs=%b expected 1", frame_start);
        end
        $display("en drop/raise: restart fs=%b h=%0d v=%0d", frame_start, H_Addr, V_Addr);
    endtask

    task automatic test_arst();
        int ones = 0;
        repeat (300) @(negedge clk);
        #1 arstn = 1'b0;
        #1;
        checks++;
        if ({rd_h, H_Addr, V_Addr, de, bin_data, hsync, vsync} !== {36'd0, 4'b0011}) begin
            failures++; $display("FAIL arst_immediate got rd_h=%0d h=%0d v=%0d de=%b bin=%b hs=%b vs=%b expected zeros, syncs 1",
                                 rd_h, H_Addr, V_Addr, de, bin_data, hsync, vsync);
        end
        repeat (3) @(negedge clk);
        #1 arstn = 1'b1;
        @(negedge clk);
        checks++;
        if (frame_start !== 1'b0) begin
            failures++; $display("FAIL arst_release_early got fs=%b expected 0", frame_start);
        end
        @(negedge clk);
        checks++;
        if ({frame_start, H_Addr, V_Addr} !== {1'b1, 24'd0}) begin
            failures++; $display("FAIL arst_release_start got fs=%b h=%0d v=%0d expected fs=1 at (0,0)", frame_start, H_Addr, V_Addr);
        end
        for (int i = 0; i < HA; i++) begin
            ones += bin_data;
            @(negedge clk);
        end
        checks++;
        if (ones != HA) begin
            failures++; $display("FAIL arst_first_line got ones=%0d expected %0d", ones, HA);
        end
        $display("arstn pulse: first line ones=%0d", ones);
    endtask

    initial begin
        test_reset();
        test_mode2_timing();
        test_bar();
        test_grey();
        test_switch();
        test_en_drop();
        test_arst();
        repeat (4) @(negedge clk);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
